sram_arbiter: RTL and testbench

Arbitrates the single quad-SPI audio SRAM between two requesters: the audio delay-line engine inside audio processing, which is real-time and has priority, and the SPI host register path, which is best effort. It sits between both requesters and the sQi SRAM interface. It serialises one word transaction at a time, latches the winner's command, and returns read data and a completion pulse to the owner. A starvation guard bounds host latency.

---
 rtl/audipus_sram_pkg.sv | 19 +
 rtl/sram_arb_select.sv | 48 ++++
 rtl/sram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audipus_sram_pkg.sv
// Shared types and defaults for the audio SRAM arbiter.
// Holds the FSM state encoding, owner codes and default widths.
package audipus_sram_pkg;

    localparam int ADDR_W_DEF       = 24;
    localparam int DATA_W_DEF       = 16;
    localparam int STARVE_LIMIT_DEF = 4;

    localparam logic OWN_AUDIO = 1'b0;
    localparam logic OWN_HOST  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } arb_state_e;

endpackage

// File: rtl/sram_arb_select.sv
// Winner selection between audio and host plus the starvation counter.
// Audio has priority until the host has watched STARVE_LIMIT audio grants.
module sram_arb_select
    import audipus_sram_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic aud_req,
    input  logic host_req,
    output logic grant,
    output logic sel_host
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved;

    always_comb begin
        starved      = (starve_cnt_q == LIMIT);
        grant        = arb_en && (aud_req || host_req);
        sel_host     = host_req && (!aud_req || starved);
        starve_cnt_d = starve_cnt_q;
        if (arb_en) begin
            if (!host_req) begin
                starve_cnt_d = '0;
            end else if (grant && sel_host) begin
                starve_cnt_d = '0;
            end else if (grant && !starved) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Serialises single-word transactions from audio and host onto the SRAM.
// Arbitration also runs in DONE so back-to-back grants are 4 cycles apart.
module sram_arbiter
    import audipus_sram_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aud_req,
    input  logic              aud_we,
    input  logic [ADDR_W-1:0] aud_addr,
    input  logic [DATA_W-1:0] aud_wdata,
    output logic              aud_gnt,
    output logic              aud_done,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              aud_gnt_q, aud_gnt_d;
    logic              host_gnt_q, host_gnt_d;
    logic              aud_done_q, aud_done_d;
    logic              host_done_q, host_done_d;
    logic              mem_start_q, mem_start_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              owner_q, owner_d;
    logic              busy_q, busy_d;

    logic arb_en;
    logic grant;
    logic sel_host;

    assign arb_en = (state_q == ST_IDLE) || (state_q == ST_DONE);

    sram_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_select (
        .clk     (clk),
        .reset   (reset),
        .arb_en  (arb_en),
        .aud_req (aud_req),
        .host_req(host_req),
        .grant   (grant),
        .sel_host(sel_host)
    );

    always_comb begin
        state_d     = state_q;
        aud_gnt_d   = 1'b0;
        host_gnt_d  = 1'b0;
        aud_done_d  = 1'b0;
        host_done_d = 1'b0;
        mem_start_d = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        owner_d     = owner_q;
        busy_d      = busy_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (grant) begin
                    state_d    = ST_ISSUE;
                    busy_d     = 1'b1;
                    owner_d    = sel_host ? OWN_HOST : OWN_AUDIO;
                    aud_gnt_d  = !sel_host;
                    host_gnt_d = sel_host;
                    if (sel_host) begin
                        mem_we_d    = host_we;
                        mem_addr_d  = host_addr;
                        mem_wdata_d = host_wdata;
                    end else begin
                        mem_we_d    = aud_we;
                        mem_addr_d  = aud_addr;
                        mem_wdata_d = aud_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                mem_start_d = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_done) begin
                    if (!mem_we_q) begin
                        rd_data_d = mem_rdata;
                    end
                    aud_done_d  = (owner_q == OWN_AUDIO);
                    host_done_d = (owner_q == OWN_HOST);
                    state_d     = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            aud_gnt_q   <= 1'b0;
            host_gnt_q  <= 1'b0;
            aud_done_q  <= 1'b0;
            host_done_q <= 1'b0;
            mem_start_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            owner_q     <= OWN_AUDIO;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            aud_gnt_q   <= aud_gnt_d;
            host_gnt_q  <= host_gnt_d;
            aud_done_q  <= aud_done_d;
            host_done_q <= host_done_d;
            mem_start_q <= mem_start_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
        end
    end

    assign aud_gnt   = aud_gnt_q;
    assign host_gnt  = host_gnt_q;
    assign aud_done  = aud_done_q;
    assign host_done = host_done_q;
    assign mem_start = mem_start_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_data   = rd_data_q;
    assign owner     = owner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an SRAM responder model
// and an expected-completion queue checked on every done pulse.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        aud_req, aud_we, host_req, host_we;
    logic [23:0] aud_addr, host_addr, mem_addr;
    logic [15:0] aud_wdata, host_wdata, mem_wdata;
    logic [15:0] rd_data, mem_rdata;
    logic        aud_gnt, aud_done, host_gnt, host_done;
    logic        mem_start, mem_we, mem_done, owner, busy;

    logic        resp_done = 1'b0;
    logic        spur_done = 1'b0;
    logic [15:0] resp_rdata = 16'h0;

    assign mem_done  = resp_done | spur_done;
    assign mem_rdata = spur_done ? 16'hDEAD : resp_rdata;

    sram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .aud_req   (aud_req),
        .aud_we    (aud_we),
        .aud_addr  (aud_addr),
        .aud_wdata (aud_wdata),
        .aud_gnt   (aud_gnt),
        .aud_done  (aud_done),
        .host_req  (host_req),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_gnt  (host_gnt),
        .host_done (host_done),
        .rd_data   (rd_data),
        .mem_start (mem_start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        own;
        logic        rd;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          gseq[$];
    int          gcyc[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    int          cnt = 0;
    int          aud_done_n = 0;
    int          host_done_n = 0;
    logic [40:0] cap = '0;
    logic [15:0] mem [logic [23:0]];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {aud_gnt, aud_done, host_gnt, host_done, rd_data,
                mem_start, mem_we, mem_addr, mem_wdata, owner, busy};
    endfunction

    function automatic logic sig(input int w);
        case (w)
            0:       return aud_gnt;
            1:       return host_gnt;
            2:       return aud_done;
            3:       return host_done;
            default: return mem_start;
        endcase
    endfunction

    // Monitor, scoreboard pop and SRAM responder share one process.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        resp_done = 1'b0;
        if (reset) begin
            cnt = 0;
        end else begin
            if (aud_gnt || host_gnt) begin
                chk("single_grant", 64'(aud_gnt & host_gnt), 64'd0);
                gseq.push_back(host_gnt ? 1 : 0);
                gcyc.push_back(cyc);
            end
            if (aud_done || host_done) begin
                aud_done_n += int'(aud_done);
                host_done_n += int'(host_done);
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("done_who", {aud_done, host_done},
                        e.own ? 2'b01 : 2'b10);
                    chk("owner", owner, e.own);
                    if (e.rd) chk("rd_data", rd_data, e.data);
                end
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    resp_done = 1'b1;
                    chk("cmd_stable", {mem_we, mem_addr, mem_wdata}, cap);
                    if (cap[40]) mem[cap[39:16]] = cap[15:0];
                    else resp_rdata = mem.exists(cap[39:16]) ?
                                      mem[cap[39:16]] : 16'h0;
                end
            end
            if (mem_start) begin
                cnt = lat;
                cap = {mem_we, mem_addr, mem_wdata};
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_for(input string tag, input int w, input int bound);
        int t = 0;
        while (!sig(w) && t < bound) begin
            step(1);
            t++;
        end
        chk(tag, 64'(sig(w)), 64'd1);
    endtask

    task automatic wait_grants(input string tag, input int n, input int bound);
        int t = 0;
        while (gseq.size() < n && t < bound) begin
            step(1);
            t++;
        end
        chk(tag, 64'(gseq.size() >= n), 64'd1);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 30) begin
            step(1);
            t++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic push_exp(input logic own, input logic rd,
                            input logic [15:0] data);
        exp_t e;
        e.own  = own;
        e.rd   = rd;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic check_seq(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < gseq.size())
                chk($sformatf("%s%0d", tag, i), 64'(gseq[i]),
                    64'((i % 5) == 4));
        end
    endtask

    initial begin
        int a0;
        int h0;
        reset = 1'b1;
        aud_req = 0; aud_we = 0; aud_addr = '0; aud_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        mem[24'h000123] = 16'hBEEF;
        mem[24'h000010] = 16'hA0A0;
        mem[24'h000020] = 16'hB0B0;
        mem[24'h000030] = 16'h3C3C;
        #1;
        chk("reset_outputs", outs(), 64'd0);
        step(2);
        reset = 1'b0;
        step(1);

        // Single audio read, SRAM answers 5 cycles after mem_start.
        lat = 5;
        push_exp(1'b0, 1'b1, 16'hBEEF);
        aud_req = 1; aud_we = 0; aud_addr = 24'h000123;
        step(1);
        chk("t1_gnt", {aud_gnt, host_gnt, busy}, 3'b101);
        aud_req = 0;
        step(1);
        chk("t1_start", {mem_start, mem_we, mem_addr},
            {1'b1, 1'b0, 24'h000123});
        step(5);
        chk("t1_pre_done", {aud_done, host_done}, 2'b00);
        step(1);
        chk("t1_done", {aud_done, host_done, host_gnt, rd_data},
            {3'b100, 16'hBEEF});
        step(1);
        chk("t1_idle", {busy, aud_done}, 2'b00);

        // Host write; responder checks the command stays put.
        lat = 3;
        push_exp(1'b1, 1'b0, 16'h0);
        host_req = 1; host_we = 1;
        host_addr = 24'h00FF00; host_wdata = 16'h1234;
        step(1);
        chk("t2_gnt", {host_gnt, aud_gnt, owner}, 3'b101);
        host_req = 0;
        step(1);
        chk("t2_cmd", {mem_start, mem_we, mem_addr, mem_wdata},
            {2'b11, 24'h00FF00, 16'h1234});
        wait_for("t2_done", 3, 20);
        step(3);
        chk("t2_done_once", 64'(host_done_n), 64'd1);
        host_we = 0;

        // Both held: A,A,A,A,H twice, 1-cycle SRAM.
        lat = 1;
        gseq.delete();
        gcyc.delete();
        aud_addr = 24'h000010; host_addr = 24'h000020;
        for (int i = 0; i < 10; i++) begin
            if ((i % 5) == 4) push_exp(1'b1, 1'b1, 16'hB0B0);
            else push_exp(1'b0, 1'b1, 16'hA0A0);
        end
        aud_req = 1; host_req = 1;
        wait_grants("t3_grants", 10, 100);
        aud_req = 0; host_req = 0;
        check_seq("t3_seq", 10);
        if (gcyc.size() >= 2)
            chk("t3_turnaround", 64'(gcyc[1] - gcyc[0]), 64'd4);
        drain("t3_drain");

        // Spurious mem_done in IDLE.
        a0 = aud_done_n;
        h0 = host_done_n;
        step(2);
        spur_done = 1;
        step(1);
        spur_done = 0;
        step(2);
        chk("t4_idle_cnt", 64'(aud_done_n + host_done_n), 64'(a0 + h0));
        chk("t4_idle_rd", rd_data, 16'hB0B0);
        chk("t4_idle_quiet", {busy, mem_start, aud_gnt, host_gnt}, 4'b0);

        // Spurious mem_done in DONE.
        aud_addr = 24'h000030;
        push_exp(1'b0, 1'b1, 16'h3C3C);
        aud_req = 1;
        wait_for("t4_gnt", 0, 10);
        aud_req = 0;
        wait_for("t4_done", 2, 20);
        spur_done = 1;
        step(1);
        spur_done = 0;
        chk("t4_done_spur", {aud_done, busy}, 2'b00);
        chk("t4_done_rd", rd_data, 16'h3C3C);
        step(2);
        chk("t4_done_cnt", 64'(aud_done_n), 64'(a0 + 1));

        // Build starve count to 3, then reset during WAIT.
        gseq.delete();
        aud_addr = 24'h000010; host_addr = 24'h000020;
        for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b1, 16'hA0A0);
        lat = 1;
        aud_req = 1; host_req = 1;
        wait_grants("t5_g2", 2, 30);
        wait_for("t5_d2", 2, 10);
        lat = 20;
        wait_grants("t5_g3", 3, 10);
        aud_req = 0; host_req = 0;
        wait_for("t5_start", 4, 10);
        step(2);
        reset = 1;
        #1;
        chk("t5_reset", outs(), 64'd0);
        chk("t5_sb_pending", 64'(sb.size()), 64'd1);
        sb.delete();
        step(1);
        reset = 0;
        step(1);
        lat = 1;
        gseq.delete();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) push_exp(1'b1, 1'b1, 16'hB0B0);
            else push_exp(1'b0, 1'b1, 16'hA0A0);
        end
        aud_req = 1; host_req = 1;
        wait_grants("t5_grants", 5, 60);
        aud_req = 0; host_req = 0;
        check_seq("t5_seq", 5);
        drain("t5_drain");

        // Reset in WAIT, then a lone host request.
        lat = 20;
        aud_req = 1;
        wait_for("t5b_gnt", 0, 10);
        aud_req = 0;
        wait_for("t5b_start", 4, 10);
        step(2);
        reset = 1;
        #1;
        chk("t5b_reset", outs(), 64'd0);
        step(1);
        reset = 0;
        step(1);
        lat = 1;
        push_exp(1'b1, 1'b1, 16'hB0B0);
        host_req = 1;
        step(1);
        chk("t5b_host_gnt", {host_gnt, aud_gnt, busy}, 3'b101);
        host_req = 0;
        wait_for("t5b_done", 3, 10);
        step(1);
        chk("t5b_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
